uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- UART receiver fed by the baud-rate tick generator, the mod-M counter whose max_tick drives s_tick at 16x the baud rate.
- Synchronises the asynchronous rx line and detects the start bit.
- Samples each bit at its midpoint using 16x oversampling.
- Delivers one received word per frame with framing and optional parity status, for a downstream FIFO or interface block.

Parameters:
- DBIT, 8, number of data bits per frame (5..9), LSB first.
- SB_TICK, 16, ticks spent in the stop state: 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- s_tick  input  1  one-clk enable pulse at 16x baud, from the mod-M counter max_tick.
- rx  input  1  serial line, asynchronous, idles high.
- rx_done_tick  output  1  one-clk pulse when a frame completes; dout and the error flags are valid from this cycle.
- dout  output  DBIT  last received word, held until the next rx_done_tick.
- frame_err  output  1  stop bit sampled low on the last frame.
- parity_err  output  1  parity mismatch on the last frame; always 0 when PARITY_EN = 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_s = 1, all outputs 0, state IDLE, s_cnt = 0, n_cnt = 0, shift register = 0.
- Reset is asynchronous and aborts any frame in progress; no rx_done_tick is issued for an aborted frame.
- rx passes through a 2-flop synchroniser (both flops reset to 1), giving rx_s with 2 clk of latency. All decisions use rx_s only.
- s_cnt is 5 bits, n_cnt is ceil(log2(DBIT)) bits. Counters advance only on s_tick; with no s_tick, all state holds.
- IDLE:
  - rx_s = 0 (no tick required): go to START, s_cnt = 0.
- START, on s_tick:
  - s_cnt = 7 and rx_s = 0: go to DATA, s_cnt = 0, n_cnt = 0.
  - s_cnt = 7 and rx_s = 1: false start; go to IDLE with no pulse and no flag change.
  - otherwise: s_cnt++.
- DATA, on s_tick:
  - s_cnt = 15: shift b = {rx_s, b[DBIT-1:1]}, s_cnt = 0.
  - If n_cnt = DBIT-1, go to PARITY when PARITY_EN = 1, otherwise STOP; else n_cnt++.
- PARITY, on s_tick:
  - s_cnt = 15: perr_next = (^b ^ rx_s ^ PARITY_ODD), s_cnt = 0, go to STOP.
- STOP, on s_tick:
  - s_cnt = SB_TICK-1: sample rx_s.
  - Register dout = b, frame_err = ~rx_s, parity_err = perr_next (0 when parity is disabled).
  - Pulse rx_done_tick for exactly one clk.
  - Go to IDLE if rx_s = 1, else to BRK.
- BRK:
  - Wait for rx_s = 1, then go to IDLE.
  - A held-low line (break) therefore yields one frame_err frame, not repeated frames.
- Frame latency: rx_done_tick rises 1 clk after the s_tick that samples the stop bit.
- Error flags are updated only together with rx_done_tick; they are not sticky across frames.
- s_tick and an rx edge in the same cycle: the edge is seen on rx_s 2 clk later; there is no special case.
- A frame's next start bit is accepted in the first clk after IDLE is re-entered.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE, START, DATA, PARITY, STOP, BRK (3-bit enum or localparams);
  - OS_RATE = 16;
  - START_MID = 7.
- One sub-module, sync_2ff: 2-flop synchroniser with a reset-value parameter, instantiated with reset value 1. It is reused later by the transmitter's cts input.

Test Plan:
- Setup for all scenarios: s_tick every 4 clk, so 1 bit = 64 clk.
- Basic frame, DBIT = 8, no parity:
  - Stimulus: send 0x5A with 1 stop bit.
  - Required: one rx_done_tick, dout = 0x5A, frame_err = 0, parity_err = 0, busy low within 1 clk after the pulse.
- Back-to-back frames:
  - Stimulus: 0x00 then 0xFF with no idle gap.
  - Required: two pulses about 640 clk apart, dout = 0x00 then 0xFF.
- False start:
  - Stimulus: rx low for 16 clk (4 ticks), then high.
  - Required: returns to IDLE, no rx_done_tick, dout and flags unchanged.
- Parity, PARITY_EN = 1, PARITY_ODD = 0:
  - Stimulus: 0x03 with parity bit 0, then 0x03 with parity bit 1.
  - Required: parity_err = 0, then parity_err = 1.
- Framing error and break:
  - Stimulus: 0xA5 with stop bit low, then rx held low for 2000 clk.
  - Required: exactly one pulse, frame_err = 1, dout = 0xA5, busy high until rx returns high.
- Reset mid-frame:
  - Stimulus: assert rst during data bit 3, release, then send 0x81.
  - Required: outputs 0 immediately on rst, no pulse for the aborted frame, next pulse has dout = 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } rx_state_e;

  localparam int OS_RATE   = 16;
  localparam int START_MID = 7;

  localparam logic [4:0] S_LAST   = 5'(OS_RATE - 1);
  localparam logic [4:0] S_MIDBIT = 5'(START_MID);

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; RST_VAL selects the
// value both flops take during reset (1 for an idle-high serial line).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with 16x oversampling: synchronises rx, finds the start bit,
// samples every bit at its midpoint and reports each frame with error status.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int         NW       = cnt_w(DBIT);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [4:0] SB_LAST  = 5'(SB_TICK - 1);
  localparam logic       ODD_BIT  = (PARITY_ODD != 0);
  localparam logic       PAR_ON   = (PARITY_EN != 0);

  // Output handshake: rx_done_tick is a one-clk valid strobe with no ready;
  // dout/frame_err/parity_err are stable from that cycle until the next strobe,
  // so the consumer must capture on the strobe and cannot apply backpressure.

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_e       state_d, state_q;
  logic [4:0]      s_cnt_d, s_cnt_q;
  logic [NW-1:0]   n_cnt_d, n_cnt_q;
  logic [DBIT-1:0] b_d, b_q;
  logic            perr_d, perr_q;
  logic [DBIT-1:0] dout_d, dout_q;
  logic            ferr_d, ferr_q;
  logic            par_err_d, par_err_q;
  logic            done_d, done_q;

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_cnt_d   = n_cnt_q;
    b_d       = b_q;
    perr_d    = perr_q;
    dout_d    = dout_q;
    ferr_d    = ferr_q;
    par_err_d = par_err_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Start detection runs every clk so a start bit directly after a
        // frame is not delayed by up to one tick.
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == S_MIDBIT) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            b_d     = {rx_s, b_q[DBIT-1:1]};
            if (n_cnt_q == N_LAST) begin
              state_d = PAR_ON ? PARITY : STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            perr_d  = (^b_q) ^ rx_s ^ ODD_BIT;
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SB_LAST) begin
            dout_d    = b_q;
            ferr_d    = ~rx_s;
            par_err_d = PAR_ON ? perr_q : 1'b0;
            done_d    = 1'b1;
            // A low stop bit parks in BRK so a held-low line reports once.
            state_d   = rx_s ? IDLE : BRK;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end

      BRK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      b_q       <= '0;
      perr_q    <= 1'b0;
      dout_q    <= '0;
      ferr_q    <= 1'b0;
      par_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      b_q       <= b_d;
      perr_q    <= perr_d;
      dout_q    <= dout_d;
      ferr_q    <= ferr_d;
      par_err_q <= par_err_d;
      done_q    <= done_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err    = ferr_q;
  assign parity_err   = par_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: one instance without parity, one with even parity,
// driven with directed and random serial frames and checked by a scoreboard.
module tb_uart_rx_os;

  localparam int BIT_CLK = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_tick = 1'b0;
  logic [1:0] tick_div = 2'd0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div <= tick_div + 2'd1;
    s_tick   <= (tick_div == 2'd2);
    cyc      <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  logic       rx_a = 1'b1, rx_p = 1'b1;
  logic       done_a, done_p;
  logic [7:0] dout_a, dout_p;
  logic       ferr_a, ferr_p, perr_a, perr_p, busy_a, busy_p;

  uart_rx_os #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .rx           (rx_a),
    .rx_done_tick (done_a),
    .dout         (dout_a),
    .frame_err    (ferr_a),
    .parity_err   (perr_a),
    .busy         (busy_a)
  );

  uart_rx_os #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .rx           (rx_p),
    .rx_done_tick (done_p),
    .dout         (dout_p),
    .frame_err    (ferr_p),
    .parity_err   (perr_p),
    .busy         (busy_p)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry = {data, frame_err, parity_err} predicted from the transmitted frame.
  logic [9:0] exp_a[$];
  logic [9:0] exp_p[$];
  int pulses_a = 0, pulses_p = 0;
  int last_pulse_a = 0;
  logic last_busy_a = 1'b0;

  always @(negedge clk) begin
    logic [9:0] e;
    if (done_a) begin
      pulses_a++;
      last_pulse_a = cyc;
      last_busy_a  = busy_a;
      if (exp_a.size() == 0) check("unexpected_pulse_a", 1, 0);
      else begin
        e = exp_a.pop_front();
        check("dout_a", dout_a, e[9:2]);
        check("frame_err_a", ferr_a, e[1]);
        check("parity_err_a", perr_a, e[0]);
      end
    end
    if (done_p) begin
      pulses_p++;
      if (exp_p.size() == 0) check("unexpected_pulse_p", 1, 0);
      else begin
        e = exp_p.pop_front();
        check("dout_p", dout_p, e[9:2]);
        check("frame_err_p", ferr_p, e[1]);
        check("parity_err_p", perr_p, e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rx(input bit to_p, input logic v);
    if (to_p) rx_p = v;
    else      rx_a = v;
  endtask

  task automatic bit_time();
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Sends start, 8 data bits LSB first, a parity bit on the parity instance,
  // and one stop bit; the line is left at the stop-bit value.
  task automatic send_frame(input bit to_p, input logic [7:0] data,
                            input logic par, input logic stop_bit);
    logic perr_exp;
    perr_exp = to_p ? (($countones({par, data}) % 2) == 1) : 1'b0;
    if (to_p) exp_p.push_back({data, ~stop_bit, perr_exp});
    else      exp_a.push_back({data, ~stop_bit, perr_exp});
    @(negedge clk);
    set_rx(to_p, 1'b0);
    bit_time();
    for (int i = 0; i < 8; i++) begin
      set_rx(to_p, data[i]);
      bit_time();
    end
    if (to_p) begin
      set_rx(to_p, par);
      bit_time();
    end
    set_rx(to_p, stop_bit);
    bit_time();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, t1, gap;
    bit to_p;
    logic [7:0] d;
    logic par, sb;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_dout", dout_a, 0);
    check("rst_frame_err", ferr_a, 0);
    check("rst_parity_err", perr_a, 0);
    check("rst_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_busy_p", busy_p, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Basic frame
    p0 = pulses_a;
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("basic_pulses", pulses_a - p0, 1);
    check("basic_dout", dout_a, 8'h5A);
    check("basic_busy_after", last_busy_a, 0);
    check("basic_idle", busy_a, 0);

    // Back-to-back
    p0 = pulses_a;
    send_frame(0, 8'h00, 1'b0, 1'b1);
    t1 = last_pulse_a;
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    gap = last_pulse_a - t1;
    repeat (20) @(negedge clk);
    check("b2b_pulses", pulses_a - p0, 2);
    check("b2b_gap_ok", (gap >= 636 && gap <= 644), 1);
    check("b2b_dout", dout_a, 8'hFF);

    // False start
    p0 = pulses_a;
    rx_a = 1'b0;
    repeat (16) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    check("false_pulses", pulses_a - p0, 0);
    check("false_dout", dout_a, 8'hFF);
    check("false_ferr", ferr_a, 0);
    check("false_busy", busy_a, 0);

    // Parity, even
    send_frame(1, 8'h03, 1'b0, 1'b1);
    rx_p = 1'b1;
    repeat (20) @(negedge clk);
    check("par_ok", perr_p, 0);
    send_frame(1, 8'h03, 1'b1, 1'b1);
    rx_p = 1'b1;
    repeat (20) @(negedge clk);
    check("par_bad", perr_p, 1);

    // Framing error then break
    p0 = pulses_a;
    send_frame(0, 8'hA5, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    check("brk_pulses", pulses_a - p0, 1);
    check("brk_ferr", ferr_a, 1);
    check("brk_dout", dout_a, 8'hA5);
    check("brk_busy_held", busy_a, 1);
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_released", busy_a, 0);
    check("brk_pulses_after", pulses_a - p0, 1);

    // Reset during data bit 3 of 0x3C
    d = 8'h3C;
    rx_a = 1'b0;
    bit_time();
    for (int i = 0; i < 3; i++) begin
      rx_a = d[i];
      bit_time();
    end
    rx_a = d[3];
    repeat (32) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_dout", dout_a, 0);
    check("mid_rst_ferr", ferr_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    p0 = pulses_a;
    send_frame(0, 8'h81, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_pulses", pulses_a - p0, 1);
    check("post_rst_dout", dout_a, 8'h81);

    // Random frames on both instances
    for (int k = 0; k < 24; k++) begin
      to_p = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      par  = 1'($urandom_range(0, 1));
      sb   = ($urandom_range(0, 5) != 0);
      send_frame(to_p, d, par, sb);
      set_rx(to_p, 1'b1);
      gap = sb ? $urandom_range(0, 40) : $urandom_range(10, 60);
      repeat (gap) @(negedge clk);
    end

    repeat (100) @(negedge clk);
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_p_drained", exp_p.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
